i2s_dac_tx: RTL and testbench

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

---
 rtl/i2s_pkg.sv | 18 +
 rtl/stereo_fifo.sv | 57 +++++
 rtl/i2s_dac_tx.sv | 168 ++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S DAC transmitter.
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/stereo_fifo.sv
// Synchronous stereo sample-pair FIFO with occupancy output.
// A write while full is still accepted when a read happens in the same cycle.
module stereo_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  stereo_t       wr_data,
  input  logic          rd_en,
  output stereo_t       rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  stereo_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Sample storage; contents need no reset because level gates all reads.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter for a WM8731-style DAC: sample-pair FIFO, bclk divider,
// 64-bit frame sequencer and MSB-first shifter with one-bit I2S delay.
// Build option: define I2S_TX_HOLD_LAST_EN to repeat the last transmitted pair on
// FIFO underrun; otherwise an underrun transmits zeros on both channels.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                tx_enable,
  input  logic                in_de,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                in_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrc,
  output logic                i2s_dacdat,
  output logic                underflow,
  output logic                overflow,
  output logic [LW-1:0]       fifo_level
);

  localparam int DW  = $clog2(BCLK_DIV);
  localparam int BW  = $clog2(FRAME_BITS);
  localparam int SPW = $clog2(SLOT_BITS);

  tx_state_t               state;
  tx_state_t               state_next;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BW-1:0]           next_bit;
  logic [SPW-1:0]          slot_pos;
  logic [2*SAMPLE_W-1:0]   shreg;
  logic                    div_wrap;
  logic                    fall;
  logic                    frame_end;
  logic                    data_slot;
  logic                    load;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  stereo_t                 fifo_rd_data;
  stereo_t                 underrun;

  stereo_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (in_de),
    .wr_data ('{left: in_left, right: in_right}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign pop      = load && !fifo_empty;

`ifdef I2S_TX_HOLD_LAST_EN
  stereo_t last_pair;

  // Remember the most recently popped pair for replay on underrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_pair <= '0;
    end else if (pop) begin
      last_pair <= fifo_rd_data;
    end
  end

  assign underrun = last_pair;
`else
  assign underrun = '0;
`endif

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, bclk edge decode and frame-load request.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    div_wrap   = (div_cnt == DW'(BCLK_DIV - 1));
    fall       = (state == RUN) && div_wrap && i2s_bclk;
    frame_end  = fall && (bit_cnt == BW'(FRAME_BITS - 1));
    next_bit   = bit_cnt + BW'(1);
    slot_pos   = next_bit[SPW-1:0];
    data_slot  = (slot_pos != '0) && (slot_pos <= SPW'(SAMPLE_W));
    case (state)
      IDLE: begin
        if (tx_enable) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (tx_enable) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider, bit counter, serial outputs, shifter and event pulses.
  // Counters and outputs sit at zero throughout IDLE, which already gives the
  // RUN entry values, so only the frame load is needed on entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrc    <= 1'b0;
      i2s_dacdat <= 1'b0;
      shreg      <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      underflow <= load && fifo_empty;
      overflow  <= in_de && fifo_full && !pop;
      if (state == RUN) begin
        if (state_next == IDLE) begin
          div_cnt    <= '0;
          bit_cnt    <= '0;
          i2s_bclk   <= 1'b0;
          i2s_lrc    <= 1'b0;
          i2s_dacdat <= 1'b0;
        end else begin
          if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
          if (fall) begin
            bit_cnt    <= next_bit;
            i2s_lrc    <= next_bit[BW-1];
            i2s_dacdat <= data_slot ? shreg[2*SAMPLE_W-1] : 1'b0;
            if (data_slot) begin
              shreg <= shreg << 1;
            end
          end
        end
      end
      if (load) begin
        shreg <= pop ? fifo_rd_data : underrun;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx (BCLK_DIV=2, FIFO_DEPTH=4).
// Serial output is captured at each bclk rising edge and compared frame by frame
// against a frame-level model of the FIFO and the I2S bit layout.
module tb_i2s_dac_tx;

  localparam int BD = 2;
  localparam int FD = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        tx_enable;
  logic        in_de;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        in_ready;
  logic        i2s_bclk;
  logic        i2s_lrc;
  logic        i2s_dacdat;
  logic        underflow;
  logic        overflow;
  logic [2:0]  fifo_level;

  i2s_dac_tx #(
    .BCLK_DIV  (BD),
    .FIFO_DEPTH(FD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_enable (tx_enable),
    .in_de     (in_de),
    .in_left   (in_left),
    .in_right  (in_right),
    .in_ready  (in_ready),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrc   (i2s_lrc),
    .i2s_dacdat(i2s_dacdat),
    .underflow (underflow),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Monitor: capture bits at bclk rising edges, plus event pulse history.
  logic rl[$];
  logic rd[$];
  int   rc[$];
  int   ufc[$];
  int   ov_cnt = 0;
  int   cyc = 0;
  logic prev_bclk = 1'b0;

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (i2s_bclk && !prev_bclk) begin
      rl.push_back(i2s_lrc);
      rd.push_back(i2s_dacdat);
      rc.push_back(cyc);
    end
    prev_bclk <= i2s_bclk;
    if (underflow) ufc.push_back(cyc);
    if (overflow) ov_cnt <= ov_cnt + 1;
  end

  // Frame-level reference model.
  logic [31:0] mq[$];
  logic [31:0] expf[$];
  logic [31:0] last_m = '0;
  int          uf_exp;
  int          ov_exp;

  task automatic model_load();
    logic [31:0] p;
    if (mq.size() > 0) begin
      p = mq.pop_front();
      last_m = p;
    end else begin
      uf_exp++;
`ifdef I2S_TX_HOLD_LAST_EN
      p = last_m;
`else
      p = '0;
`endif
    end
    expf.push_back(p);
  endtask

  task automatic model_push(input logic [31:0] p);
    if (mq.size() < FD) mq.push_back(p);
    else ov_exp++;
  endtask

  function automatic logic [63:0] exp_lrc();
    logic [63:0] v;
    v = '0;
    for (int b = 32; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_dat(input logic [31:0] p);
    logic [63:0] v;
    v = '0;
    for (int b = 1; b <= 16; b++) v[b] = p[32-b];
    for (int b = 33; b <= 48; b++) v[b] = p[48-b];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_bit(input int n);
    int t;
    t = 0;
    while (rl.size() < n && t < 20000) begin
      @(negedge sys_clk);
      t++;
    end
    if (rl.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_bit timeout actual=%0d required=%0d", rl.size(), n);
    end
  endtask

  task automatic push(input logic [31:0] p);
    @(posedge sys_clk); #1;
    in_de = 1'b1;
    in_left = p[31:16];
    in_right = p[15:0];
    @(posedge sys_clk); #1;
    in_de = 1'b0;
  endtask

  task automatic do_reset();
    tx_enable = 1'b0;
    in_de = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    mq.delete();
    last_m = '0;
  endtask

  // Run nf frames, pushing a random pair mid-frame in frames 1..n_mid, optionally
  // writing a pair in the same cycle as RUN entry; drop enable at bit 10 of the last frame.
  task automatic play(input int nf, input int n_mid, input bit entry_push);
    int base, ufb, ovb, bad;
    logic [31:0] p;
    logic [63:0] al, ad;
    base = rl.size();
    ufb = ufc.size();
    ovb = ov_cnt;
    expf.delete();
    uf_exp = 0;
    ov_exp = 0;
    p = $urandom;
    @(posedge sys_clk); #1;
    tx_enable = 1'b1;
    if (entry_push) begin
      in_de = 1'b1;
      in_left = p[31:16];
      in_right = p[15:0];
    end
    @(posedge sys_clk); #1;
    in_de = 1'b0;
    model_load();
    if (entry_push) begin
      model_push(p);
      chk("entry_level", 64'(fifo_level), 64'(mq.size()));
      chk("entry_overflow", 64'(overflow), 64'(0));
    end
    for (int k = 0; k < nf; k++) begin
      if (k > 0) model_load();
      if (k == nf - 1) begin
        wait_bit(base + 64 * k + 10);
        tx_enable = 1'b0;
      end else if (k >= 1 && k <= n_mid) begin
        wait_bit(base + 64 * k + 20);
        p = $urandom;
        push(p);
        model_push(p);
      end
    end
    repeat (128 * BD + 64) @(posedge sys_clk);
    #1;
    chk("rise_count", 64'(rl.size() - base), 64'(64 * nf));
    for (int f = 0; f < nf; f++) begin
      al = '0;
      ad = '0;
      for (int b = 0; b < 64; b++) begin
        int i;
        i = base + 64 * f + b;
        if (i < rl.size()) begin
          al[b] = rl[i];
          ad[b] = rd[i];
        end else begin
          al[b] = 1'bx;
          ad[b] = 1'bx;
        end
      end
      chk($sformatf("frame%0d_lrc", f), al, exp_lrc());
      chk($sformatf("frame%0d_dat", f), ad, exp_dat(expf[f]));
    end
    bad = 0;
    for (int i = base + 1; i < rl.size(); i++) if (rc[i] - rc[i-1] != 2 * BD) bad++;
    chk("bclk_period", 64'(bad), 64'(0));
    chk("underflow_count", 64'(ufc.size() - ufb), 64'(uf_exp));
    bad = 0;
    for (int i = ufb + 1; i < ufc.size(); i++) if (ufc[i] - ufc[i-1] != 128 * BD) bad++;
    chk("underflow_spacing", 64'(bad), 64'(0));
    chk("overflow_count", 64'(ov_cnt - ovb), 64'(ov_exp));
    chk("level_after", 64'(fifo_level), 64'(mq.size()));
    chk("idle_outputs", 64'({i2s_bclk, i2s_lrc, i2s_dacdat}), 64'(0));
  endtask

  typedef struct {
    logic        de;
    logic [31:0] pair;
    logic        exp_ready;
    logic [2:0]  exp_level;
    logic        exp_ov;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] p;
    sys_rst_n = 1'b0;
    tx_enable = 1'b0;
    in_de = 1'b0;
    in_left = '0;
    in_right = '0;

    // Reset state, sampled while reset is held.
    #7;
    chk("rst_bclk", 64'(i2s_bclk), 64'(0));
    chk("rst_lrc", 64'(i2s_lrc), 64'(0));
    chk("rst_dacdat", 64'(i2s_dacdat), 64'(0));
    chk("rst_underflow", 64'(underflow), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    do_reset();

    // FIFO fill while IDLE: fifth pair dropped with an overflow pulse.
    tbl[0] = '{1'b1, 32'hA5A5_5A5A, 1'b1, 3'd1, 1'b0};
    tbl[1] = '{1'b1, $urandom, 1'b1, 3'd2, 1'b0};
    tbl[2] = '{1'b1, $urandom, 1'b1, 3'd3, 1'b0};
    tbl[3] = '{1'b1, $urandom, 1'b0, 3'd4, 1'b0};
    tbl[4] = '{1'b1, $urandom, 1'b0, 3'd4, 1'b1};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 3'd4, 1'b0};
    for (int n = 0; n < 6; n++) begin
      @(posedge sys_clk); #1;
      in_de = tbl[n].de;
      in_left = tbl[n].pair[31:16];
      in_right = tbl[n].pair[15:0];
      @(posedge sys_clk); #1;
      in_de = 1'b0;
      chk($sformatf("fill%0d_ready", n), 64'(in_ready), 64'(tbl[n].exp_ready));
      chk($sformatf("fill%0d_level", n), 64'(fifo_level), 64'(tbl[n].exp_level));
      chk($sformatf("fill%0d_overflow", n), 64'(overflow), 64'(tbl[n].exp_ov));
      if (tbl[n].de) model_push(tbl[n].pair);
    end

    // Full FIFO, write together with the entry pop, then run into underrun.
    play(9, 2, 1'b1);

    // Enable dropped at bit 10: frame completes, nothing further popped.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      p = $urandom;
      push(p);
      model_push(p);
    end
    play(1, 0, 1'b0);

    // Empty FIFO after one known pair: underflow once per frame.
    do_reset();
    push(32'h1234_4321);
    model_push(32'h1234_4321);
    play(3, 0, 1'b0);

    // Reset asserted mid-frame at bit 40, then a fresh frame after release.
    do_reset();
    push($urandom);
    begin
      int base;
      base = rl.size();
      @(posedge sys_clk); #1;
      tx_enable = 1'b1;
      wait_bit(base + 40);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({i2s_bclk, i2s_lrc, i2s_dacdat, underflow, overflow}), 64'(0));
    chk("midrst_level", 64'(fifo_level), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(1));
    tx_enable = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    mq.delete();
    last_m = '0;
    p = $urandom;
    push(p);
    model_push(p);
    play(1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
